// File: rtl/param_pkg.sv
// Shared types and constants for the L1 MSHR snoop path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package param_pkg;

  localparam int DCACHE_TAG_WIDTH   = 6;
  localparam int DCACHE_INDEX_WIDTH = 4;

  // Transient states of an outstanding miss; IS_I marks a pending shared
  // fill whose line was invalidated by a snoop before the data arrived.
  typedef enum logic [1:0] {
    IS   = 2'd0,
    IM   = 2'd1,
    SM   = 2'd2,
    IS_I = 2'd3
  } transient_state_t;

  // Snoop type encoding on ac_snoop_i
  localparam logic SNP_SHARED = 1'b0;
  localparam logic SNP_INV    = 1'b1;

  // Snoop response codes on cr_resp_o
  localparam logic [1:0] CR_MISS  = 2'b00;
  localparam logic [1:0] CR_ACK   = 2'b01;
  localparam logic [1:0] CR_RETRY = 2'b10;

  // MSHR write-pointer select: entry captured by the last snoop lookup
  localparam logic [1:0] WR_PTR_PREV_SNOOP = 2'b10;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/snoop_decide.sv
// Maps (hit, transient state, snoop type) to MSHR update and snoop response.
// Latency: purely combinational.
// Backpressure: none; caller samples the result when it needs it.
`timescale 1ns/1ps
module snoop_decide
  import param_pkg::*;
(
  input  logic             hit,
  input  transient_state_t state,
  input  logic             snoop,
  output logic             write_en,
  output transient_state_t new_state,
  output logic [1:0]       resp
);

  // Decision table; IM entries cannot give up ownership mid-miss, so they retry
  always_comb begin
    write_en  = 1'b0;
    new_state = state;
    resp      = CR_MISS;
    if (hit) begin
      case (state)
        IS: begin
          resp = CR_ACK;
          if (snoop == SNP_INV) begin
            write_en  = 1'b1;
            new_state = IS_I;
          end
        end
        SM: begin
          resp = CR_ACK;
          if (snoop == SNP_INV) begin
            write_en  = 1'b1;
            new_state = IM;
          end
        end
        IM:      resp = CR_RETRY;
        IS_I:    resp = CR_ACK;
        default: resp = CR_ACK;
      endcase
    end
  end

endmodule

// File: rtl/mshr_snoop_ctrl.sv
// Snoop front end of the L1 MSHR: lookup, transient-state update, response.
// Latency: response 2 cycles after accept (3 when the entry is rewritten).
// Backpressure: one snoop in flight; ac_ready_o low until the response handshakes.
`timescale 1ns/1ps
module mshr_snoop_ctrl
  import param_pkg::*;
#(
  parameter int ADR_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ac_valid_i,
  output logic             ac_ready_o,
  input  logic [ADR_W-1:0] ac_adr_i,
  input  logic             ac_snoop_i,
  output logic             cr_valid_o,
  input  logic             cr_ready_i,
  output logic [1:0]       cr_resp_o,
  output logic             mshr_snoop_req_o,
  output logic [ADR_W-1:0] mshr_snoop_adr_o,
  input  logic             mshr_read_hit_i,
  input  transient_state_t mshr_state_i,
  output logic             mshr_we_o,
  output logic [1:0]       mshr_wr_ptr_sel_o,
  output transient_state_t mshr_state_o,
  output logic             mshr_valid_o,
  output logic [ADR_W-1:0] mshr_adr_o,
  output logic             mshr_lock_o
);

  ctrl_state_t      state_q;
  logic             ready_q;
  logic             lock_q;
  logic             we_q;
  logic             cr_valid_q;
  logic [1:0]       resp_q;
  logic [ADR_W-1:0] adr_q;
  logic             snoop_q;
  transient_state_t wstate_q;

  logic             accept;
  logic             dec_we;
  transient_state_t dec_state;
  logic [1:0]       dec_resp;

  // Lookup is launched in the accept cycle itself so the MSHR answers in LOOKUP
  assign accept = (state_q == ST_IDLE) && ac_valid_i && !reset;

  snoop_decide u_decide (
    .hit       (mshr_read_hit_i),
    .state     (mshr_state_i),
    .snoop     (snoop_q),
    .write_en  (dec_we),
    .new_state (dec_state),
    .resp      (dec_resp)
  );

  // Sequencer: decision is captured once in LOOKUP so later MSHR reads cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      lock_q     <= 1'b0;
      we_q       <= 1'b0;
      cr_valid_q <= 1'b0;
      resp_q     <= CR_MISS;
      adr_q      <= '0;
      snoop_q    <= SNP_SHARED;
      wstate_q   <= IS;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            adr_q   <= ac_adr_i;
            snoop_q <= ac_snoop_i;
            ready_q <= 1'b0;
            lock_q  <= 1'b1;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          wstate_q <= dec_state;
          resp_q   <= dec_resp;
          if (dec_we) begin
            we_q    <= 1'b1;
            state_q <= ST_UPDATE;
          end else begin
            lock_q     <= 1'b0;
            cr_valid_q <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_UPDATE: begin
          we_q       <= 1'b0;
          lock_q     <= 1'b0;
          cr_valid_q <= 1'b1;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (cr_ready_i) begin
            cr_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ac_ready_o        = ready_q;
  assign cr_valid_o        = cr_valid_q;
  assign cr_resp_o         = resp_q;
  assign mshr_snoop_req_o  = accept;
  assign mshr_snoop_adr_o  = ac_adr_i;
  // Reset landing in UPDATE must not let the registered strobe reach the MSHR
  assign mshr_we_o         = we_q && !reset;
  assign mshr_wr_ptr_sel_o = WR_PTR_PREV_SNOOP;
  assign mshr_state_o      = wstate_q;
  assign mshr_valid_o      = 1'b1;
  assign mshr_adr_o        = adr_q;
  assign mshr_lock_o       = lock_q || accept;

endmodule

// File: tb/tb_mshr_snoop_ctrl.sv
// Bench for mshr_snoop_ctrl with a small behavioural MSHR and reference decision.
// Latency: n/a.
// Backpressure: exercised via cr_ready_i stalls and held ac_valid_i.
`timescale 1ns/1ps
module tb_mshr_snoop_ctrl;
  import param_pkg::*;

  localparam int ADR_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int N_ENT = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ac_valid = 1'b0;
  logic             ac_ready;
  logic [ADR_W-1:0] ac_adr = '0;
  logic             ac_snoop = 1'b0;
  logic             cr_valid;
  logic             cr_ready = 1'b0;
  logic [1:0]       cr_resp;
  logic             snoop_req;
  logic [ADR_W-1:0] snoop_adr;
  logic             hit_r = 1'b0;
  transient_state_t st_r = IS;
  logic             mshr_we;
  logic [1:0]       wr_sel;
  transient_state_t state_o;
  logic             valid_o;
  logic [ADR_W-1:0] adr_o;
  logic             lock;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mshr_snoop_ctrl #(.ADR_W(ADR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .ac_valid_i        (ac_valid),
    .ac_ready_o        (ac_ready),
    .ac_adr_i          (ac_adr),
    .ac_snoop_i        (ac_snoop),
    .cr_valid_o        (cr_valid),
    .cr_ready_i        (cr_ready),
    .cr_resp_o         (cr_resp),
    .mshr_snoop_req_o  (snoop_req),
    .mshr_snoop_adr_o  (snoop_adr),
    .mshr_read_hit_i   (hit_r),
    .mshr_state_i      (st_r),
    .mshr_we_o         (mshr_we),
    .mshr_wr_ptr_sel_o (wr_sel),
    .mshr_state_o      (state_o),
    .mshr_valid_o      (valid_o),
    .mshr_adr_o        (adr_o),
    .mshr_lock_o       (lock)
  );

  // Behavioural MSHR: associative table, registered lookup result, snoop-pointer writes
  typedef struct packed {
    logic             vld;
    logic [ADR_W-1:0] adr;
    transient_state_t st;
  } ent_t;

  ent_t             ent [N_ENT];
  int               ptr_r = 0;
  int               mk;
  logic             l1_re = 1'b0;
  transient_state_t l1_re_st = IS;
  logic             poke_en = 1'b0;
  int               poke_idx = 0;
  ent_t             poke_val = '0;
  logic [ADR_W-1:0] pool [N_ENT] = '{10'h040, 10'h0B2, 10'h155, 10'h2C7};

  function automatic int find(input logic [ADR_W-1:0] a);
    for (int i = 0; i < N_ENT; i++)
      if (ent[i].vld === 1'b1 && ent[i].adr === a) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (poke_en) ent[poke_idx] <= poke_val;
    if (snoop_req) begin
      mk = find(snoop_adr);
      hit_r <= (mk >= 0);
      st_r  <= (mk >= 0) ? ent[mk].st : IS;
      ptr_r <= (mk >= 0) ? mk : 0;
    end else if (l1_re) begin
      st_r <= l1_re_st;
    end
    if (mshr_we === 1'b1 && wr_sel == 2'b10)
      ent[ptr_r] <= '{vld: valid_o, adr: adr_o, st: state_o};
  end

  // Reference decision written from the coherence rules
  function automatic void ref_decide(input logic hit, input transient_state_t st, input logic typ,
                                     output logic we, output transient_state_t nst,
                                     output logic [1:0] resp);
    resp = !hit ? 2'b00 : (st == IM) ? 2'b10 : 2'b01;
    we   = hit && typ && (st == IS || st == SM);
    nst  = (st == IS) ? IS_I : IM;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic vld, input logic [ADR_W-1:0] a,
                      input transient_state_t st);
    poke_idx = idx;
    poke_val = '{vld: vld, adr: a, st: st};
    poke_en  = 1'b1;
    @(posedge clk); #1;
    poke_en  = 1'b0;
  endtask

  // One complete snoop; starts at a drive point with the DUT idle
  task automatic snoop(input logic [ADR_W-1:0] a, input logic typ, input int stall,
                       input bit ovr, input transient_state_t ovr_st, input bit hold);
    int k;
    logic hit;
    transient_state_t st;
    logic e_we;
    transient_state_t e_st;
    logic [1:0] e_resp;
    k   = find(a);
    hit = (k >= 0);
    st  = hit ? ent[k].st : IS;
    ref_decide(hit, st, typ, e_we, e_st, e_resp);
    ac_valid = 1'b1; ac_adr = a; ac_snoop = typ; cr_ready = (stall == 0);
    #1;
    chk("acc_ready", ac_ready, 1); chk("acc_req", snoop_req, 1);
    chk("acc_adr", snoop_adr, a);  chk("acc_lock", lock, 1);
    @(posedge clk); #1;
    ac_valid = hold; l1_re = ovr; l1_re_st = ovr_st;
    #1;
    chk("lk_ready", ac_ready, 0); chk("lk_req", snoop_req, 0); chk("lk_lock", lock, 1);
    chk("lk_we", mshr_we, 0);     chk("lk_crv", cr_valid, 0);
    @(posedge clk); #1;
    l1_re = 1'b0;
    #1;
    if (e_we) begin
      chk("up_we", mshr_we, 1);      chk("up_sel", wr_sel, 2'b10);
      chk("up_state", state_o, e_st); chk("up_valid", valid_o, 1);
      chk("up_adr", adr_o, a);        chk("up_lock", lock, 1);
      chk("up_crv", cr_valid, 0);
      @(posedge clk); #2;
    end else begin
      chk("nowr_we", mshr_we, 0);
    end
    chk("rsp_crv", cr_valid, 1);   chk("rsp_resp", cr_resp, e_resp);
    chk("rsp_lock", lock, 0);      chk("rsp_ready", ac_ready, 0);
    chk("rsp_req", snoop_req, 0);  chk("rsp_we", mshr_we, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) cr_ready = 1'b1;
      #1;
      chk("stl_crv", cr_valid, 1);   chk("stl_resp", cr_resp, e_resp);
      chk("stl_ready", ac_ready, 0); chk("stl_req", snoop_req, 0);
    end
    @(posedge clk); #1;
    chk("done_crv", cr_valid, 0); chk("done_ready", ac_ready, 1);
    if (!hold) ac_valid = 1'b0;
  endtask

  initial begin
    logic [ADR_W-1:0] ra;
    // Reset with an empty MSHR
    for (int i = 0; i < N_ENT; i++) poke(i, 1'b0, '0, IS);
    #1;
    chk("rst_ready", ac_ready, 1); chk("rst_crv", cr_valid, 0);
    chk("rst_resp", cr_resp, 0);   chk("rst_req", snoop_req, 0);
    chk("rst_we", mshr_we, 0);     chk("rst_lock", lock, 0);
    chk("rst_adr", adr_o, 0);      chk("rst_state", state_o, IS);
    @(posedge clk); #1;
    reset = 1'b0;

    // Miss on empty MSHR
    snoop(10'h1A3, SNP_INV, 0, 1'b0, IS, 1'b0);

    for (int i = 0; i < N_ENT; i++) poke(i, 1'b1, pool[i], transient_state_t'(i == 0 ? IS : i == 1 ? IM : i == 2 ? SM : IS_I));

    // IS + invalidate, then follow-up lookup sees IS_I
    snoop(10'h040, SNP_INV, 0, 1'b0, IS, 1'b0);
    chk("ent040_isi", ent[0].st, IS_I);
    snoop(10'h040, SNP_INV, 0, 1'b0, IS, 1'b0);

    // IM retries and stays IM
    snoop(10'h0B2, SNP_SHARED, 0, 1'b0, IS, 1'b0);
    chk("ent0b2_im", ent[1].st, IM);

    // Backpressure with a held second request
    snoop(10'h155, SNP_SHARED, 5, 1'b0, IS, 1'b1);
    snoop(10'h155, SNP_SHARED, 0, 1'b0, IS, 1'b0);

    // Late MSHR read overwrites state after LOOKUP; decision must use SM
    snoop(10'h155, SNP_INV, 0, 1'b1, IS_I, 1'b0);
    chk("ent155_im", ent[2].st, IM);

    // Reset while UPDATE is pending
    poke(0, 1'b1, 10'h040, IS);
    ac_valid = 1'b1; ac_adr = 10'h040; ac_snoop = SNP_INV; cr_ready = 1'b1;
    @(posedge clk); #1;
    ac_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rupd_we", mshr_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rupd_crv", cr_valid, 0); chk("rupd_we2", mshr_we, 0);
    chk("rupd_lock", lock, 0);    chk("rupd_ready", ac_ready, 1);
    chk("rupd_ent", ent[0].st, IS);
    snoop(10'h040, SNP_INV, 0, 1'b0, IS, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0)
        poke($urandom_range(0, N_ENT - 1) , ($urandom_range(0, 3) != 0),
             pool[$urandom_range(0, N_ENT - 1)], transient_state_t'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) != 0) ra = pool[$urandom_range(0, N_ENT - 1)];
      else ra = ADR_W'($urandom);
      snoop(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, IS, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mshr_snoop_ctrl.md
# mshr_snoop_ctrl

Snoop-side front end of the L1 MSHR: accepts coherence snoops from the interconnect one at a time. For each snoop it:
- launches an associative lookup in the MSHR,
- decides the transient-state update and snoop response from the hit/state it reads back,
- writes the update into the matching MSHR entry using the "previous snoop pointer" write mode,
- returns a response to the interconnect.

It sits between the interconnect snoop channel and the MSHR snoop/write ports, alongside the L1 miss controller, which owns the MSHR write port whenever this block does not hold the lock.

## Interface
Parameters:
- ADR_W, DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH, line address width (tag+index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high; one clock, synchronous, active-high reset.
- ac_valid_i  in  1  snoop request valid.
- ac_ready_o  out  1  snoop request accepted; high only in IDLE.
- ac_adr_i  in  ADR_W  snooped line address.
- ac_snoop_i  in  1  snoop type: 0 = SNP_SHARED, 1 = SNP_INV.
- cr_valid_o  out  1  snoop response valid.
- cr_ready_i  in  1  response consumed.
- cr_resp_o  out  2  response code: 00 = MISS, 01 = ACK, 10 = RETRY.
- mshr_snoop_req_o  out  1  MSHR lookup strobe.
- mshr_snoop_adr_o  out  ADR_W  lookup address.
- mshr_read_hit_i  in  1  registered MSHR hit, valid the cycle after the strobe.
- mshr_state_i  in  transient_state_t  registered transient state of the hit entry.
- mshr_we_o  out  1  MSHR write enable.
- mshr_wr_ptr_sel_o  out  2  write-pointer select; constant 2'b10 (previous snoop pointer).
- mshr_state_o  out  transient_state_t  state written to the entry.
- mshr_valid_o  out  1  entry valid bit written; always 1.
- mshr_adr_o  out  ADR_W  address rewritten to the entry (the latched snoop address).
- mshr_lock_o  out  1  MSHR snoop and write ports owned by this block; the L1 controller holds off its writes while this is high.

## Operation
- FSM states and transitions:
  - IDLE: ac_ready_o=1. On ac_valid_i, latch the address and type, drive mshr_snoop_req_o=1 with mshr_snoop_adr_o=ac_adr_i combinationally in the same cycle, then go to LOOKUP.
  - LOOKUP: sample mshr_read_hit_i/mshr_state_i into registers and compute the decision (below). If a write is needed go to UPDATE, else go to RESP.
  - UPDATE: mshr_we_o=1 for exactly one cycle with the decided state, then go to RESP.
  - RESP: cr_valid_o=1 with a stable cr_resp_o until cr_ready_i, then go to IDLE.
- Decision:
  - No hit: MISS, no write.
  - IS, SNP_SHARED: ACK, no write.
  - IS, SNP_INV: write IS_I, ACK.
  - SM, SNP_SHARED: ACK, no write.
  - SM, SNP_INV: write IM, ACK.
  - IM (either type): RETRY, no write; the requester reissues later.
  - IS_I (either type): ACK, no write.
- mshr_lock_o is high in the IDLE accept cycle and throughout LOOKUP and UPDATE; low in RESP and in non-accepting IDLE.
- Only one snoop is in flight; no other lookup is issued while one is outstanding, so the MSHR's captured snoop pointer is still valid in UPDATE.

## Timing
- Reset values: state=IDLE, ac_ready_o=1, cr_valid_o=0, cr_resp_o=00, mshr_snoop_req_o=0, mshr_we_o=0, mshr_lock_o=0, latched address/type/state all zero.
- Latency, accept edge = cycle 0:
  - cr_valid_o asserts in cycle 2 when no write is needed, cycle 3 when a write is needed.
  - Minimum throughput is one snoop per 3 cycles (no write, cr_ready_i held high).
- cr_valid_o/cr_resp_o hold stable while cr_ready_i=0; the response completes on the edge where both are high.
- ac_ready_o is 0 during LOOKUP, UPDATE and RESP; there is no back-to-back acceptance in the RESP completion cycle.
- mshr_state_i is sampled in LOOKUP only. A later MSHR re_i overwriting the MSHR output register must not affect the decision.
- Reset asserted in any state: next cycle IDLE, cr_valid_o=0, mshr_we_o=0, mshr_lock_o=0; the pending snoop is dropped and no write occurs.
- ac_valid_i outside IDLE is ignored; the requester holds its request.

## Structure
- param_pkg holds:
  - transient_state_t, extended with IS_I if it is absent;
  - snoop type constants SNP_SHARED/SNP_INV;
  - response codes CR_MISS/CR_ACK/CR_RETRY;
  - DCACHE_TAG_WIDTH/DCACHE_INDEX_WIDTH.
- One natural sub-module: snoop_decide, a purely combinational function (hit, state, type) -> (write_en, new_state, resp), verified standalone.

## Test plan
- Miss: SNP_INV to addr 0x1A3, MSHR empty -> cr_resp_o=00 in cycle 2, mshr_we_o never high, lock high cycles 0–1.
- IS + SNP_INV on addr 0x040 -> mshr_we_o=1 in cycle 2 with sel=10, state=IS_I, valid=1; ACK (01) in cycle 3; a follow-up lookup of 0x040 returns IS_I.
- IM hit, SNP_SHARED -> RETRY (10) in cycle 2, no write; entry still IM.
- Backpressure: cr_ready_i held low for 5 cycles -> cr_valid_o/cr_resp_o stable, ac_ready_o=0, second ac_valid_i not accepted until one cycle after the response handshake.
- Reset asserted in UPDATE -> no MSHR write takes effect, all outputs at reset values the next cycle, and a new snoop is accepted normally afterwards.
- MSHR re_i by the L1 controller in the LOOKUP+1 cycle changing mshr_state_i -> the decision uses the LOOKUP-sampled state.
